// File: rtl/invaders_game_ctrl.sv
// Game-state sequencer for the Space Invaders datapath: formation, ship, bullet, win/lose.
// Optional INVADERS_SPEEDUP_EN halves the formation period while 1..4 invaders remain.
module invaders_game_ctrl #(
  parameter int unsigned INVADER_PERIOD = 30,
  parameter int unsigned BULLET_PERIOD  = 4,
  parameter int unsigned SHIP_PERIOD    = 6,
  parameter int unsigned SHIP_ROW       = 13,
  parameter logic [19:0] INIT_ARRAY     = 20'h0FFF0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_frame_tick,
  input  logic        i_left,
  input  logic        i_right,
  input  logic        i_fire,
  output logic [19:0] o_invaders_array,
  output logic [3:0]  o_invaders_line,
  output logic [4:0]  o_ship_x,
  output logic [4:0]  o_bullet_x,
  output logic [3:0]  o_bullet_y,
  output logic        o_bullet_flying,
  output logic [1:0]  o_gameplay
);

  typedef enum logic [1:0] {
    PLAYING   = 2'b00,
    YOU_WIN   = 2'b01,
    GAME_OVER = 2'b10
  } gameplay_t;

  localparam logic [7:0] INV_LAST    = 8'(INVADER_PERIOD - 1);
  localparam logic [7:0] BUL_LAST    = 8'(BULLET_PERIOD - 1);
  localparam logic [7:0] SHIP_LAST   = 8'(SHIP_PERIOD - 1);
  localparam logic [3:0] SHIP_ROW_M1 = 4'(SHIP_ROW - 1);

  gameplay_t   state_q, state_d;
  logic [19:0] array_q, array_d;
  logic [3:0]  line_q, line_d;
  logic [4:0]  ship_q, ship_d;
  logic [4:0]  bx_q, bx_d;
  logic [3:0]  by_q, by_d;
  logic        fly_q, fly_d;
  logic        dir_q, dir_d;
  logic [7:0]  inv_cnt_q, inv_cnt_d;
  logic [7:0]  bul_cnt_q, bul_cnt_d;
  logic [7:0]  ship_cnt_q, ship_cnt_d;
  logic        fire_q;

  logic        fire_edge, hit, inv_step, bul_step, ship_step, lose;
  logic [19:0] hit_mask, arr_v;
  logic [7:0]  inv_limit;

`ifdef INVADERS_SPEEDUP_EN
  logic [4:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < 20; i++) pop = pop + 5'(array_q[i]);
    inv_limit = INV_LAST;
    if (pop >= 5'd1 && pop <= 5'd4) inv_limit = 8'(INVADER_PERIOD / 2 - 1);
  end
`else
  assign inv_limit = INV_LAST;
`endif

  assign fire_edge = i_fire & ~fire_q;
  // Masked lookup keeps an out-of-range column from ever addressing past bit 19.
  assign hit_mask  = (bx_q < 5'd20) ? (20'd1 << bx_q) : '0;
  assign hit       = fly_q && (by_q == line_q) && (|(array_q & hit_mask));

  always_comb begin
    state_d    = state_q;
    array_d    = array_q;
    line_d     = line_q;
    ship_d     = ship_q;
    bx_d       = bx_q;
    by_d       = by_q;
    fly_d      = fly_q;
    dir_d      = dir_q;
    inv_cnt_d  = inv_cnt_q;
    bul_cnt_d  = bul_cnt_q;
    ship_cnt_d = ship_cnt_q;
    inv_step   = 1'b0;
    bul_step   = 1'b0;
    ship_step  = 1'b0;
    lose       = 1'b0;
    arr_v      = hit ? (array_q & ~hit_mask) : array_q;

    case (state_q)
      PLAYING: begin
        if (i_frame_tick) begin
          if (inv_cnt_q >= inv_limit) begin
            inv_cnt_d = '0;
            inv_step  = (inv_cnt_q == inv_limit);
          end else begin
            inv_cnt_d = inv_cnt_q + 8'd1;
          end
          if (bul_cnt_q >= BUL_LAST) begin
            bul_cnt_d = '0;
            bul_step  = 1'b1;
          end else begin
            bul_cnt_d = bul_cnt_q + 8'd1;
          end
          if (i_left || i_right) begin
            if (ship_cnt_q >= SHIP_LAST) begin
              ship_cnt_d = '0;
              ship_step  = 1'b1;
            end else begin
              ship_cnt_d = ship_cnt_q + 8'd1;
            end
          end
        end
        if (!i_left && !i_right) ship_cnt_d = '0;

        if (ship_step && i_left && !i_right && ship_q != 5'd0)   ship_d = ship_q - 5'd1;
        if (ship_step && i_right && !i_left && ship_q != 5'd19)  ship_d = ship_q + 5'd1;

        // The formation step operates on the array with any hit already removed.
        array_d = arr_v;
        if (inv_step) begin
          if ((!dir_q && !arr_v[19]) || (dir_q && !arr_v[0])) begin
            array_d = dir_q ? (arr_v >> 1) : (arr_v << 1);
          end else if (line_q == SHIP_ROW_M1) begin
            lose = 1'b1;
          end else begin
            line_d = line_q + 4'd1;
            dir_d  = ~dir_q;
          end
        end

        if (hit) begin
          fly_d = 1'b0;
        end else if (fly_q) begin
          if (bul_step) begin
            if (by_q == 4'd0) fly_d = 1'b0;
            else              by_d  = by_q - 4'd1;
          end
        end else if (fire_edge) begin
          bx_d      = ship_q;
          by_d      = SHIP_ROW_M1;
          fly_d     = 1'b1;
          bul_cnt_d = '0;
        end

        if (array_d == '0) state_d = YOU_WIN;
        else if (lose)     state_d = GAME_OVER;
      end
      default: begin
        if (fire_edge) begin
          state_d    = PLAYING;
          array_d    = INIT_ARRAY;
          line_d     = '0;
          ship_d     = 5'd10;
          bx_d       = '0;
          by_d       = '0;
          fly_d      = 1'b0;
          dir_d      = 1'b0;
          inv_cnt_d  = '0;
          bul_cnt_d  = '0;
          ship_cnt_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q    <= PLAYING;
      array_q    <= INIT_ARRAY;
      line_q     <= '0;
      ship_q     <= 5'd10;
      bx_q       <= '0;
      by_q       <= '0;
      fly_q      <= 1'b0;
      dir_q      <= 1'b0;
      inv_cnt_q  <= '0;
      bul_cnt_q  <= '0;
      ship_cnt_q <= '0;
      fire_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      array_q    <= array_d;
      line_q     <= line_d;
      ship_q     <= ship_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      fly_q      <= fly_d;
      dir_q      <= dir_d;
      inv_cnt_q  <= inv_cnt_d;
      bul_cnt_q  <= bul_cnt_d;
      ship_cnt_q <= ship_cnt_d;
      fire_q     <= i_fire;
    end
  end

  assign o_invaders_array = array_q;
  assign o_invaders_line  = line_q;
  assign o_ship_x         = ship_q;
  assign o_bullet_x       = bx_q;
  assign o_bullet_y       = by_q;
  assign o_bullet_flying  = fly_q;
  assign o_gameplay       = state_q;

endmodule
